// File: rtl/fault_classifier_pkg.sv
// fault_classifier_pkg: shared fault codes and classifier FSM state encodings.
package fault_classifier_pkg;
  typedef enum logic [2:0] {
    CODE_NONE       = 3'd0,
    CODE_ECC_CORR   = 3'd1,
    CODE_ECC_UNCORR = 3'd2,
    CODE_LOCKSTEP   = 3'd3,
    CODE_WATCHDOG   = 3'd4,
    CODE_ESCALATED  = 3'd5
  } fault_code_e;
  typedef enum logic [1:0] {IDLE, WAIT_ACK, BUSY} state_e;
endpackage

// File: rtl/fault_classifier_window_counter.sv
// fault_window_counter: minor-fault escalation window timer with saturating count.
module fault_window_counter #(
  parameter int WINDOW_CYCLES = 64,
  parameter int ESC_THRESHOLD = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hit,
  output logic       escalate,
  output logic [3:0] minor_count
);
  localparam int WW = WINDOW_CYCLES > 1 ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WW-1:0] LAST = WW'(WINDOW_CYCLES - 1);
  localparam logic [3:0] THR = 4'(ESC_THRESHOLD);
  localparam bit THR_OK = ESC_THRESHOLD >= 1 && ESC_THRESHOLD <= 15;
  logic open, expire;
  logic [WW-1:0] timer;
  logic [3:0] base, bumped;
  // an expiring window and a new hit on the same edge: the hit opens a fresh window
  assign expire = open && timer == LAST;
  assign base = expire ? 4'd0 : minor_count;
  assign bumped = base == 4'd15 ? base : base + 4'd1;
  assign escalate = THR_OK && hit && bumped == THR;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      open <= 1'b0;
      timer <= '0;
      minor_count <= 4'd0;
    end else if (escalate || (expire && !hit)) begin
      open <= 1'b0;
      timer <= '0;
      minor_count <= 4'd0;
    end else if (hit) begin
      open <= 1'b1;
      timer <= open && !expire ? timer + 1'b1 : '0;
      minor_count <= bumped;
    end else if (open) timer <= timer + 1'b1;
endmodule

// File: rtl/fault_classifier.sv
// fault_classifier: prioritises fault sources into one-cycle minor/critical reports
// with ack timeout re-issue, pending critical latching and minor escalation.
module fault_classifier
  import fault_classifier_pkg::*;
#(
  parameter int WINDOW_CYCLES = 64,
  parameter int ESC_THRESHOLD = 3,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ecc_corrected,
  input  logic       ecc_uncorrectable,
  input  logic       lockstep_mismatch,
  input  logic       watchdog_expired,
  input  logic       recovery_busy,
  output logic       minor_fault,
  output logic       critical_fault,
  output logic [2:0] fault_code,
  output logic [3:0] minor_count
);
  localparam int TW = ACK_TIMEOUT > 1 ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
  state_e state, state_n;
  fault_code_e code, code_n, pend, pend_n, crit_code, event_code;
  logic minor_n, crit_n, last_crit, last_crit_n, hit, esc, report;
  logic [TW-1:0] tmo, tmo_n;
  assign crit_code = ecc_uncorrectable ? CODE_ECC_UNCORR :
                     lockstep_mismatch ? CODE_LOCKSTEP :
                     watchdog_expired  ? CODE_WATCHDOG : CODE_NONE;
  assign hit = ecc_corrected && crit_code == CODE_NONE;
  assign event_code = crit_code != CODE_NONE ? crit_code : esc ? CODE_ESCALATED : CODE_NONE;
  assign report = pend != CODE_NONE || event_code != CODE_NONE;
  assign fault_code = code;
  fault_window_counter #(.WINDOW_CYCLES(WINDOW_CYCLES), .ESC_THRESHOLD(ESC_THRESHOLD)) u_window (
    .clk(clk), .reset(reset), .hit(hit), .escalate(esc), .minor_count(minor_count)
  );
  always_comb begin
    state_n = state;
    code_n = code;
    pend_n = pend;
    minor_n = 1'b0;
    crit_n = 1'b0;
    last_crit_n = last_crit;
    tmo_n = tmo;
    case (state)
      IDLE: if (report || hit) begin
        // a pending critical wins; anything critical sampled now becomes the next pending
        code_n = pend != CODE_NONE ? pend : event_code != CODE_NONE ? event_code : CODE_ECC_CORR;
        pend_n = pend != CODE_NONE ? event_code : CODE_NONE;
        crit_n = report;
        minor_n = !report;
        last_crit_n = report;
        tmo_n = '0;
        state_n = WAIT_ACK;
      end
      WAIT_ACK: begin
        pend_n = pend == CODE_NONE ? event_code : pend;
        state_n = recovery_busy ? BUSY : WAIT_ACK;
        crit_n = !recovery_busy && tmo == TMO_LAST && last_crit;
        minor_n = !recovery_busy && tmo == TMO_LAST && !last_crit;
        tmo_n = tmo == TMO_LAST ? '0 : tmo + 1'b1;
      end
      default: begin
        pend_n = pend == CODE_NONE ? event_code : pend;
        state_n = recovery_busy ? BUSY : IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      code <= CODE_NONE;
      pend <= CODE_NONE;
      minor_fault <= 1'b0;
      critical_fault <= 1'b0;
      last_crit <= 1'b0;
      tmo <= '0;
    end else begin
      state <= state_n;
      code <= code_n;
      pend <= pend_n;
      minor_fault <= minor_n;
      critical_fault <= crit_n;
      last_crit <= last_crit_n;
      tmo <= tmo_n;
    end
endmodule

// File: tb/tb_fault_classifier.sv
// tb_fault_classifier: directed scenarios plus randomized traffic checked against
// an event-level reference model of the classifier.
module tb_fault_classifier;
  localparam int WIN = 64, THR = 3, TMO = 16;
  logic clk = 1'b0, reset = 1'b1;
  logic ecc_corrected = 0, ecc_uncorrectable = 0, lockstep_mismatch = 0, watchdog_expired = 0, recovery_busy = 0;
  logic minor_fault, critical_fault;
  logic [2:0] fault_code;
  logic [3:0] minor_count;
  int checks = 0, passed = 0;
  int cyc = 0, m_state = 0, win_start = -1, m_count = 0, m_pend = 0, last_rep = 0, m_code = 0;
  bit m_last_crit = 0, m_minor = 0, m_crit = 0;

  fault_classifier dut (
    .clk(clk), .reset(reset), .ecc_corrected(ecc_corrected), .ecc_uncorrectable(ecc_uncorrectable),
    .lockstep_mismatch(lockstep_mismatch), .watchdog_expired(watchdog_expired), .recovery_busy(recovery_busy),
    .minor_fault(minor_fault), .critical_fault(critical_fault), .fault_code(fault_code), .minor_count(minor_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0; win_start = -1; m_count = 0; m_pend = 0; m_code = 0;
    m_minor = 0; m_crit = 0; last_rep = 0; m_last_crit = 0;
  endtask

  // One sampling edge of the classifier, expressed as event bookkeeping in absolute cycle numbers.
  task automatic model_edge();
    int crit, ev;
    bit hit, esc;
    crit = ecc_uncorrectable ? 2 : lockstep_mismatch ? 3 : watchdog_expired ? 4 : 0;
    hit = ecc_corrected && crit == 0;
    esc = 0;
    if (win_start >= 0 && cyc - win_start >= WIN) begin win_start = -1; m_count = 0; end
    if (hit) begin
      if (win_start < 0) win_start = cyc;
      if (m_count < 15) m_count++;
      if (m_count == THR) begin esc = 1; m_count = 0; win_start = -1; end
    end
    ev = crit != 0 ? crit : esc ? 5 : 0;
    m_minor = 0; m_crit = 0;
    if (m_state == 0) begin
      if (m_pend != 0) begin m_crit = 1; m_code = m_pend; m_pend = ev; end
      else if (ev != 0) begin m_crit = 1; m_code = ev; end
      else if (hit) begin m_minor = 1; m_code = 1; end
      if (m_crit || m_minor) begin m_state = 1; last_rep = cyc; m_last_crit = m_crit; end
    end else begin
      if (m_pend == 0) m_pend = ev;
      if (m_state == 1 && recovery_busy) m_state = 2;
      else if (m_state == 1 && cyc - last_rep >= TMO) begin
        m_crit = m_last_crit; m_minor = !m_last_crit; last_rep = cyc;
      end else if (m_state == 2 && !recovery_busy) m_state = 0;
    end
    cyc++;
  endtask

  task automatic step(input bit c, u, l, w, b);
    ecc_corrected = c; ecc_uncorrectable = u; lockstep_mismatch = l; watchdog_expired = w; recovery_busy = b;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    ecc_corrected = 0; ecc_uncorrectable = 0; lockstep_mismatch = 0; watchdog_expired = 0; recovery_busy = 0;
    reset = 1;
    model_reset();
    @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic test_reset();
    int pulses = 0;
    #12;
    checks++; if (minor_fault !== 1'b0) $display("FAIL reset_minor got %b want 0", minor_fault); else passed++;
    checks++; if (critical_fault !== 1'b0) $display("FAIL reset_crit got %b want 0", critical_fault); else passed++;
    checks++; if (fault_code !== 3'd0) $display("FAIL reset_code got %0d want 0", fault_code); else passed++;
    checks++; if (minor_count !== 4'd0) $display("FAIL reset_count got %0d want 0", minor_count); else passed++;
    @(posedge clk);
    #1 reset = 0;
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    #2 reset = 1;
    #1;
    checks++; if (fault_code !== 3'd0) $display("FAIL async_reset_code got %0d want 0", fault_code); else passed++;
    checks++; if (minor_count !== 4'd0) $display("FAIL async_reset_count got %0d want 0", minor_count); else passed++;
    model_reset();
    @(posedge clk);
    #1 reset = 0;
    for (int i = 0; i < 24; i++) begin
      step(0, 0, 0, 0, 0);
      pulses += minor_fault + critical_fault;
    end
    checks++; if (pulses != 0) $display("FAIL reset_no_reissue got %0d pulses want 0", pulses); else passed++;
  endtask

  task automatic test_minor_ack();
    do_reset();
    step(1, 0, 0, 0, 0);
    checks++; if (minor_fault !== 1'b1) $display("FAIL minor_pulse got %b want 1", minor_fault); else passed++;
    checks++; if (critical_fault !== 1'b0) $display("FAIL minor_nocrit got %b want 0", critical_fault); else passed++;
    checks++; if (fault_code !== 3'd1) $display("FAIL minor_code got %0d want 1", fault_code); else passed++;
    checks++; if (minor_count !== 4'd1) $display("FAIL minor_count got %0d want 1", minor_count); else passed++;
    step(0, 0, 0, 0, 0);
    checks++; if (minor_fault !== 1'b0) $display("FAIL minor_width got %b want 0", minor_fault); else passed++;
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    checks++; if (minor_fault !== 1'b1) $display("FAIL minor_after_idle got %b want 1", minor_fault); else passed++;
    checks++; if (minor_count !== 4'd2) $display("FAIL minor_count2 got %0d want 2", minor_count); else passed++;
  endtask

  task automatic test_priority();
    do_reset();
    step(1, 0, 1, 0, 0);
    checks++; if (critical_fault !== 1'b1 || minor_fault !== 1'b0) $display("FAIL prio_ls_pulse got crit=%b minor=%b want 1/0", critical_fault, minor_fault); else passed++;
    checks++; if (fault_code !== 3'd3) $display("FAIL prio_ls_code got %0d want 3", fault_code); else passed++;
    checks++; if (minor_count !== 4'd0) $display("FAIL prio_ls_count got %0d want 0", minor_count); else passed++;
    do_reset();
    step(1, 1, 1, 1, 0);
    checks++; if (fault_code !== 3'd2) $display("FAIL prio_all_code got %0d want 2", fault_code); else passed++;
    do_reset();
    step(0, 0, 1, 1, 0);
    checks++; if (fault_code !== 3'd3) $display("FAIL prio_lw_code got %0d want 3", fault_code); else passed++;
    do_reset();
    step(0, 0, 0, 1, 0);
    checks++; if (fault_code !== 3'd4 || critical_fault !== 1'b1) $display("FAIL prio_wd got code=%0d crit=%b want 4/1", fault_code, critical_fault); else passed++;
  endtask

  task automatic ack_gap(input int cycles);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    for (int i = 3; i < cycles - 1; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic test_escalation();
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      step(1, 0, 0, 0, 0);
      if (k < 3) begin
        checks++; if (minor_fault !== 1'b1 || fault_code !== 3'd1) $display("FAIL esc_minor%0d got minor=%b code=%0d want 1/1", k, minor_fault, fault_code); else passed++;
        checks++; if (minor_count !== 4'(k)) $display("FAIL esc_count%0d got %0d want %0d", k, minor_count, k); else passed++;
        ack_gap(10);
      end
    end
    checks++; if (critical_fault !== 1'b1 || minor_fault !== 1'b0) $display("FAIL esc_crit got crit=%b minor=%b want 1/0", critical_fault, minor_fault); else passed++;
    checks++; if (fault_code !== 3'd5) $display("FAIL esc_code got %0d want 5", fault_code); else passed++;
    checks++; if (minor_count !== 4'd0) $display("FAIL esc_count_clear got %0d want 0", minor_count); else passed++;
  endtask

  task automatic test_window_expiry();
    do_reset();
    step(1, 0, 0, 0, 0);
    ack_gap(70);
    step(1, 0, 0, 0, 0);
    checks++; if (minor_fault !== 1'b1) $display("FAIL win_minor got %b want 1", minor_fault); else passed++;
    checks++; if (minor_count !== 4'd1) $display("FAIL win_count got %0d want 1", minor_count); else passed++;
  endtask

  task automatic test_timeout();
    do_reset();
    step(0, 1, 0, 0, 0);
    checks++; if (critical_fault !== 1'b1) $display("FAIL tmo_first got %b want 1", critical_fault); else passed++;
    for (int i = 1; i <= 40; i++) begin
      step(0, 0, 0, 0, 0);
      checks++; if (critical_fault !== (i % TMO == 0) || minor_fault !== 1'b0) $display("FAIL tmo_cycle%0d got crit=%b minor=%b want %b/0", i, critical_fault, minor_fault, i % TMO == 0); else passed++;
    end
    checks++; if (fault_code !== 3'd2) $display("FAIL tmo_code got %0d want 2", fault_code); else passed++;
  endtask

  task automatic test_pending();
    do_reset();
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    checks++; if (critical_fault !== 1'b0 || fault_code !== 3'd3) $display("FAIL pend_hold got crit=%b code=%0d want 0/3", critical_fault, fault_code); else passed++;
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    checks++; if (critical_fault !== 1'b0) $display("FAIL pend_idle_entry got %b want 0", critical_fault); else passed++;
    step(0, 0, 0, 0, 0);
    checks++; if (critical_fault !== 1'b1 || fault_code !== 3'd4) $display("FAIL pend_report got crit=%b code=%0d want 1/4", critical_fault, fault_code); else passed++;
  endtask

  task automatic test_random(input int minor_odds, input int crit_odds, input int n);
    bit busy = 0;
    do_reset();
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(7) == 0) busy = !busy;
      step($urandom_range(minor_odds - 1) == 0, $urandom_range(crit_odds - 1) == 0,
           $urandom_range(crit_odds - 1) == 0, $urandom_range(crit_odds - 1) == 0, busy);
      checks++; if (minor_fault !== m_minor) $display("FAIL rnd_minor cyc %0d got %b want %b", i, minor_fault, m_minor); else passed++;
      checks++; if (critical_fault !== m_crit) $display("FAIL rnd_crit cyc %0d got %b want %b", i, critical_fault, m_crit); else passed++;
      checks++; if (fault_code !== 3'(m_code)) $display("FAIL rnd_code cyc %0d got %0d want %0d", i, fault_code, m_code); else passed++;
      checks++; if (minor_count !== 4'(m_count)) $display("FAIL rnd_count cyc %0d got %0d want %0d", i, minor_count, m_count); else passed++;
      checks++; if (minor_fault && critical_fault) $display("FAIL rnd_exclusive cyc %0d got both pulses want at most one", i); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_minor_ack();
    test_priority();
    test_escalation();
    test_window_expiry();
    test_timeout();
    test_pending();
    test_random(5, 60, 800);
    test_random(40, 200, 1500);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/fault_classifier.md
FAULT_CLASSIFIER -- requirements
Module: fault_classifier

Interface
REQ-001 Parameter WINDOW_CYCLES, default 64: length in cycles of the minor-fault escalation window.
REQ-002 Parameter ESC_THRESHOLD, default 3: number of minor faults within one window that escalates to critical.
REQ-003 Parameter ACK_TIMEOUT, default 16: cycles to wait for recovery_busy before re-issuing a report.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 ecc_corrected  in  1  single-bit corrected ECC error; minor source.
REQ-007 ecc_uncorrectable  in  1  uncorrectable ECC error; critical source.
REQ-008 lockstep_mismatch  in  1  lockstep compare failure; critical source.
REQ-009 watchdog_expired  in  1  watchdog timeout; critical source.
REQ-010 recovery_busy  in  1  high while the downstream recovery FSM is freezing or recovering.
REQ-011 minor_fault  out  1  one-cycle minor-fault pulse to the recovery FSM.
REQ-012 critical_fault  out  1  one-cycle critical-fault pulse to the recovery FSM.
REQ-013 fault_code  out  3  code of the last report: 0 NONE, 1 ECC_CORR, 2 ECC_UNCORR, 3 LOCKSTEP, 4 WATCHDOG, 5 ESCALATED.
REQ-014 minor_count  out  4  current minor count in the open window, saturating at 15.

Function
REQ-015 Inputs SHALL be sampled on each rising edge; a report pulse is asserted in the cycle following the sampling edge, exactly one cycle wide.
REQ-016 minor_fault and critical_fault SHALL never be asserted in the same cycle.
REQ-017 Critical priority when several are sampled together SHALL be ecc_uncorrectable > lockstep_mismatch > watchdog_expired; a critical source beats any minor source.
REQ-018 A minor fault sampled together with a critical source SHALL NOT be counted.
REQ-019 FSM states SHALL be IDLE, WAIT_ACK and BUSY.
REQ-020 IDLE: on a sampled fault, issue the report, load fault_code, and go to WAIT_ACK.
REQ-021 WAIT_ACK: when recovery_busy=1, go to BUSY.
REQ-022 WAIT_ACK: if recovery_busy stays 0 for ACK_TIMEOUT cycles, re-issue the same pulse type and code, restart the timeout, and stay in WAIT_ACK.
REQ-023 BUSY: when recovery_busy=0, go to IDLE.
REQ-024 In WAIT_ACK or BUSY, critical sources SHALL NOT pulse; the first critical sampled SHALL be latched as pending with its code, and later ones are dropped.
REQ-025 A pending critical SHALL be reported the cycle after IDLE is re-entered, taking priority over new inputs sampled that edge.
REQ-026 In WAIT_ACK or BUSY, minor faults SHALL only increment minor_count; they produce no pulse.
REQ-027 The first counted minor fault SHALL open a window of WINDOW_CYCLES cycles.
REQ-028 Window expiry SHALL clear minor_count to 0 and close the window.
REQ-029 When a counted minor fault makes minor_count reach ESC_THRESHOLD, the block SHALL issue critical_fault with code 5 instead of minor_fault, and clear the count and window.
REQ-030 If escalation occurs outside IDLE, code 5 SHALL be latched as pending only if no critical is already pending.
REQ-031 fault_code SHALL hold its value until the next report.

Reset
REQ-032 On reset assertion, immediately: state=IDLE, minor_fault=0, critical_fault=0, fault_code=0, minor_count=0, window closed, pending cleared, timeout counter=0.
REQ-033 Reset asserted mid-report or mid-WAIT_ACK SHALL discard the pending and in-flight report without re-issue after release.

Structure
REQ-034 Fault code values and FSM state encodings SHALL live in the shared project package; parameter defaults stay in the module.
REQ-035 The window timer and saturating minor counter SHALL be one sub-module, fault_window_counter; the FSM and priority logic stay in fault_classifier.

Verification
REQ-036 Single ecc_corrected pulse in IDLE, recovery_busy raised 2 cycles later -> one minor_fault pulse next cycle, fault_code=1, minor_count=1, FSM returns to IDLE when busy drops.
REQ-037 lockstep_mismatch and ecc_corrected in the same cycle -> critical_fault only, fault_code=3, minor_count unchanged.
REQ-038 Three ecc_corrected pulses 10 cycles apart, each acknowledged -> minor, minor, then critical_fault with fault_code=5, minor_count=0.
REQ-039 Two ecc_corrected pulses 70 cycles apart -> both minor, minor_count=1 after the second (window expired).
REQ-040 ecc_uncorrectable with recovery_busy held 0 -> critical_fault re-pulsed every 16 cycles, fault_code=2.
REQ-041 watchdog_expired during BUSY, then busy drops -> critical_fault exactly 1 cycle after IDLE entry, fault_code=4.
